// File: rtl/alu_seq_top_if.sv
// Board-side bundle for the sequential ALU: switch/button inputs
// and the result/flag/status outputs that drive the LEDs.
interface alu_seq_top_if #(
  parameter int NB_DATA = 8
) ();
  logic [NB_DATA-1:0] sw;
  logic               btn_a;
  logic               btn_b;
  logic               btn_op;
  logic [NB_DATA-1:0] result;
  logic               carry;
  logic               zero;
  logic               overflow;
  logic               valid;
  logic               busy;
  logic               err;

  modport master (
    output sw, btn_a, btn_b, btn_op,
    input  result, carry, zero, overflow,
    input  valid, busy, err
  );

  modport slave (
    input  sw, btn_a, btn_b, btn_op,
    output result, carry, zero, overflow,
    output valid, busy, err
  );
endinterface

// File: rtl/alu_seq_top.sv
// Sequential ALU front-end: button-loaded operands/opcode, flags,
// valid/busy/err status and bit-serial variable shifts.
module alu_seq_top #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = 3
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_carry,
  output logic               o_zero,
  output logic               o_overflow,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_err
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  localparam int MSB = NB_DATA - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT
  } state_e;

  state_e              state_q, state_d;
  logic [NB_DATA-1:0]  a_q, a_d;
  logic [NB_DATA-1:0]  b_q, b_d;
  logic [NB_OP-1:0]    op_q, op_d;
  logic [NB_DATA-1:0]  work_q, work_d;
  logic [NB_SHAMT-1:0] cnt_q, cnt_d;
  logic [NB_DATA-1:0]  res_q, res_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                btn_a_q, btn_b_q, btn_op_q;

  logic               idle;
  logic               acc_a, acc_b, acc_op;
  logic [NB_OP-1:0]   sw_op;
  logic               op_legal, op_shift;
  logic [NB_DATA:0]   sum_w, dif_w;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_c, alu_v;
  logic [NB_DATA-1:0] shift_nxt;

  assign idle  = (state_q == S_IDLE);
  assign sw_op = i_sw[NB_OP-1:0];

  // Priority A > B > OP; anything seen while busy is dropped.
  assign acc_a  = idle & i_btn_a & ~btn_a_q;
  assign acc_b  = idle & i_btn_b & ~btn_b_q & ~acc_a;
  assign acc_op = idle & i_btn_op & ~btn_op_q
                & ~(i_btn_a & ~btn_a_q)
                & ~(i_btn_b & ~btn_b_q);

  always_comb begin
    op_legal = 1'b1;
    op_shift = 1'b0;
    case (sw_op)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_XOR, OP_NOR: op_legal = 1'b1;
      OP_SRA, OP_SRL:        op_shift = 1'b1;
      default:               op_legal = 1'b0;
    endcase
  end

  assign sum_w = {1'b0, a_q} + {1'b0, b_q};
  assign dif_w = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[NB_DATA];
        alu_v   = (a_q[MSB] == b_q[MSB]) & (sum_w[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = dif_w[MSB:0];
        alu_c   = dif_w[NB_DATA];
        alu_v   = (a_q[MSB] != b_q[MSB]) & (dif_w[MSB] != a_q[MSB]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      default: alu_res = '0;
    endcase
  end

  assign shift_nxt = {(op_q == OP_SRA) & work_q[MSB], work_q[MSB:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    err_d   = err_q;

    if (acc_a) begin
      a_d     = i_sw;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
    if (acc_b) begin
      b_d     = i_sw;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
    if (acc_op) begin
      op_d    = sw_op;
      valid_d = 1'b0;
      err_d   = ~op_legal;
      if (op_shift) begin
        state_d = S_SHIFT;
        work_d  = a_q;
        cnt_d   = b_q[NB_SHAMT-1:0];
      end else if (op_legal) begin
        state_d = S_EXEC;
      end
    end

    case (state_q)
      S_EXEC: begin
        res_d   = alu_res;
        carry_d = alu_c;
        ovf_d   = alu_v;
        zero_d  = (alu_res == '0);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          work_d = shift_nxt;
          cnt_d  = cnt_q - NB_SHAMT'(1);
        end else begin
          res_d   = work_q;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = (work_q == '0);
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      btn_a_q  <= 1'b0;
      btn_b_q  <= 1'b0;
      btn_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      btn_a_q  <= i_btn_a;
      btn_b_q  <= i_btn_b;
      btn_op_q <= i_btn_op;
    end
  end

  assign o_result   = res_q;
  assign o_carry    = carry_q;
  assign o_zero     = zero_q;
  assign o_overflow = ovf_q;
  assign o_valid    = valid_q;
  assign o_busy     = ~idle;
  assign o_err      = err_q;

endmodule
